// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, data width and baud-divider helper shared by the UART blocks.
`default_nettype none

package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter; bit_tick marks the last clock of each bit period.
`default_nettype none

module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   output logic bit_tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] clk_count;

   // Wrapping on the tick keeps consecutive bits exactly CLKS_PER_BIT long.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_count <= '0;
      end else if (clear || bit_tick) begin
         clk_count <= '0;
      end else begin
         clk_count <= clk_count + 1'b1;
      end
   end

   assign bit_tick = !clear && (clk_count == LAST);

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// uart_tx: valid/ready byte in, framed serial out (start, 8 data LSB-first, optional parity, 1-2 stop).
`default_nettype none

module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 9600,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_line,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);

   if (CLKS_PER_BIT < 2) begin : g_bad_clks
      $error("uart_tx: CLKS_PER_BIT must be at least 2");
   end
   if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end

   uart_state_t state, state_next;
   logic [7:0]  shreg, shreg_next;
   logic [2:0]  bit_idx, bit_idx_next;
   logic        stop_cnt, stop_cnt_next;
   logic        parity_bit;
   logic        line_next;
   logic        done_next;
   logic        bit_tick;
   logic        accept;

   assign accept = tx_valid && tx_ready;

   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (state == IDLE),
      .bit_tick(bit_tick)
   );

   always_comb begin
      state_next    = state;
      shreg_next    = shreg;
      bit_idx_next  = bit_idx;
      stop_cnt_next = stop_cnt;
      done_next     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next    = START;
               shreg_next    = tx_data;
               bit_idx_next  = 3'd0;
               stop_cnt_next = 1'b0;
            end
         end
         START: begin
            if (bit_tick) state_next = DATA;
         end
         DATA: begin
            if (bit_tick) begin
               if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
                  state_next = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_idx_next = bit_idx + 3'd1;
                  shreg_next   = {1'b0, shreg[7:1]};
               end
            end
         end
         PARITY: begin
            if (bit_tick) state_next = STOP;
         end
         STOP: begin
            if (bit_tick) begin
               if (stop_cnt == 1'(STOP_BITS - 1)) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else begin
                  stop_cnt_next = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      // The line register is loaded from the next state so each bit starts on its edge.
      case (state_next)
         START:   line_next = 1'b0;
         DATA:    line_next = shreg_next[0];
         PARITY:  line_next = parity_bit;
         default: line_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         shreg      <= 8'h00;
         bit_idx    <= 3'd0;
         stop_cnt   <= 1'b0;
         parity_bit <= 1'b0;
         tx_line    <= 1'b1;
         tx_busy    <= 1'b0;
         tx_done    <= 1'b0;
         tx_ready   <= 1'b1;
      end else begin
         state    <= state_next;
         shreg    <= shreg_next;
         bit_idx  <= bit_idx_next;
         stop_cnt <= stop_cnt_next;
         tx_line  <= line_next;
         tx_busy  <= (state_next != IDLE);
         tx_ready <= (state_next == IDLE);
         tx_done  <= done_next;
         if (accept) begin
            parity_bit <= (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx framing, handshake, parity, stop bits and reset.
`default_nettype none

module tb_uart_tx;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [2:0] valid;
   logic [7:0] data [3];
   wire  [2:0] ready, line, busy, done;

   int  pass_cnt  = 0;
   int  total_cnt = 0;
   time stop_t;
   time first_t;

   always #5 clk = ~clk;

   // dut0: 8N1; dut1: even parity, 2 stop; dut2: odd parity, 1 stop. All 16 clk/bit.
   uart_tx #(.CLK_FREQ(16), .BAUD_RATE(1)) dut0 (
      .clk(clk), .reset_n(reset_n), .tx_data(data[0]), .tx_valid(valid[0]),
      .tx_ready(ready[0]), .tx_line(line[0]), .tx_busy(busy[0]), .tx_done(done[0]));
   uart_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
      .clk(clk), .reset_n(reset_n), .tx_data(data[1]), .tx_valid(valid[1]),
      .tx_ready(ready[1]), .tx_line(line[1]), .tx_busy(busy[1]), .tx_done(done[1]));
   uart_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
      .clk(clk), .reset_n(reset_n), .tx_data(data[2]), .tx_valid(valid[2]),
      .tx_ready(ready[2]), .tx_line(line[2]), .tx_busy(busy[2]), .tx_done(done[2]));

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Accept d on instance inst, then check every cycle of the frame through the tx_done cycle.
   task automatic run_frame(input int inst, input logic [7:0] d, input int pe, input logic pb,
                            input int stops, input int stop_at, input int poke_cycle);
      int   n;
      int   idx;
      logic exp_line;
      n = 16 * (9 + pe + stops);
      data[inst]  = d;
      valid[inst] = 1'b1;
      @(posedge clk);
      #1;
      valid[inst] = 1'b0;
      data[inst]  = ~d;
      for (int c = 1; c <= n + 1; c++) begin
         @(negedge clk);
         if (c == poke_cycle) begin
            valid[inst] = 1'b1;
            data[inst]  = 8'hFF;
         end
         if (c == poke_cycle + 1) begin
            valid[inst] = 1'b0;
            data[inst]  = 8'h00;
         end
         if (c == 1) first_t = $time;
         if (c == 16 * (9 + pe) + 1) stop_t = $time;
         idx = (c - 1) / 16;
         if (idx == 0)                 exp_line = 1'b0;
         else if (idx <= 8)            exp_line = d[idx-1];
         else if (pe != 0 && idx == 9) exp_line = pb;
         else                          exp_line = 1'b1;
         total_cnt++;
         if (line[inst] !== exp_line)
            $display("FAIL tx_line inst%0d byte %h cycle %0d: got %b want %b", inst, d, c, line[inst], exp_line);
         else pass_cnt++;
         total_cnt++;
         if (busy[inst] !== (c <= n))
            $display("FAIL tx_busy inst%0d byte %h cycle %0d: got %b want %b", inst, d, c, busy[inst], (c <= n));
         else pass_cnt++;
         total_cnt++;
         if (done[inst] !== (c == n + 1))
            $display("FAIL tx_done inst%0d byte %h cycle %0d: got %b want %b", inst, d, c, done[inst], (c == n + 1));
         else pass_cnt++;
         total_cnt++;
         if (ready[inst] !== (c == n + 1))
            $display("FAIL tx_ready inst%0d byte %h cycle %0d: got %b want %b", inst, d, c, ready[inst], (c == n + 1));
         else pass_cnt++;
         if (c == stop_at) return;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      valid   = 3'b000;
      for (int i = 0; i < 3; i++) data[i] = 8'h00;
      idle(3);
      total_cnt++;
      if ({line, busy, done, ready} !== {3'b111, 3'b000, 3'b000, 3'b111})
         $display("FAIL reset_values: got line=%b busy=%b done=%b ready=%b want 111/000/000/111", line, busy, done, ready);
      else pass_cnt++;
      reset_n = 1'b1;
      idle(3);
      total_cnt++;
      if ({line, busy, ready} !== {3'b111, 3'b000, 3'b111})
         $display("FAIL idle_after_reset: got line=%b busy=%b ready=%b want 111/000/111", line, busy, ready);
      else pass_cnt++;
   endtask

   task automatic test_basic();
      run_frame(0, 8'hA5, 0, 1'b0, 1, 0, -5);
   endtask

   task automatic test_back_to_back();
      time prev_stop;
      prev_stop = stop_t;
      run_frame(0, 8'h3C, 0, 1'b0, 1, 0, -5);
      total_cnt++;
      if ((first_t - prev_stop) != 170)
         $display("FAIL b2b_gap: got %0d clks want 17", (first_t - prev_stop) / 10);
      else pass_cnt++;
      idle(5);
   endtask

   task automatic test_parity_stop();
      run_frame(1, 8'h07, 1, 1'b1, 2, 0, -5);
      idle(5);
      run_frame(2, 8'h07, 1, 1'b0, 1, 0, -5);
      idle(5);
      run_frame(1, 8'hA5, 1, 1'b0, 2, 0, -5);
      idle(5);
   endtask

   task automatic test_ignore_busy();
      run_frame(0, 8'h5A, 0, 1'b0, 1, 0, 50);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         total_cnt++;
         if ({line[0], busy[0]} !== 2'b10)
            $display("FAIL no_second_frame cycle %0d: got line=%b busy=%b want 1/0", c, line[0], busy[0]);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid_frame();
      run_frame(0, 8'h96, 0, 1'b0, 1, 70, -5);
      #2;
      reset_n = 1'b0;
      #1;
      total_cnt++;
      if ({line[0], busy[0], ready[0], done[0]} !== 4'b1010)
         $display("FAIL async_reset: got line=%b busy=%b ready=%b done=%b want 1/0/1/0", line[0], busy[0], ready[0], done[0]);
      else pass_cnt++;
      @(negedge clk);
      reset_n = 1'b1;
      idle(3);
      run_frame(0, 8'h96, 0, 1'b0, 1, 0, -5);
      idle(3);
      // Reset asserted across an accept edge drops the byte.
      data[0]  = 8'h00;
      valid[0] = 1'b1;
      reset_n  = 1'b0;
      @(posedge clk);
      #1;
      valid[0] = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         total_cnt++;
         if ({line[0], busy[0]} !== 2'b10)
            $display("FAIL reset_wins cycle %0d: got line=%b busy=%b want 1/0", c, line[0], busy[0]);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_parity_stop();
      test_ignore_busy();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

`default_nettype wire
